tinker_iter_alu: RTL and testbench

- Parametrised, handshaked multi-cycle execute unit for the tinker multi-cycle core.
- Handles the existing tinker ALU opcode set.
- Add/sub/logic ops complete in a single cycle.
- mul and div run iteratively, one bit per cycle, instead of as combinational 64-bit multiply/divide.
- Sits between the decode/operand latches (A/B/imm mux) and the writeback stage. The core FSM stalls on the valid/ready handshake instead of assuming fixed latency.

---
 rtl/tinker_iter_alu_pkg.sv | 34 +++
 rtl/tinker_iter_alu_if.sv | 29 ++
 rtl/tinker_iter_alu_divider.sv | 71 +++++++
 rtl/tinker_iter_alu.sv | 142 ++++++++++++++
 tb/tb_tinker_iter_alu.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/tinker_iter_alu_pkg.sv
// Shared opcodes, FSM state type and opcode-class helper for the tinker execute unit.
// TINKER_ALU_FAST_MUL_EN makes mul a single-cycle op.
package tinker_pkg;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_XOR  = 5'b00010;
  localparam logic [4:0] OP_NOT  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b11000;
  localparam logic [4:0] OP_ADDI = 5'b11001;
  localparam logic [4:0] OP_SUB  = 5'b11010;
  localparam logic [4:0] OP_SUBI = 5'b11011;
  localparam logic [4:0] OP_MUL  = 5'b11100;
  localparam logic [4:0] OP_DIV  = 5'b11101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_single_cycle(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
      OP_AND, OP_OR, OP_XOR, OP_NOT: return 1'b1;
`ifdef TINKER_ALU_FAST_MUL_EN
      OP_MUL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tinker_iter_alu_if.sv
// Request/result handshake bundle between the operand latches, the execute unit and writeback.
interface tinker_iter_alu_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5,
  parameter int OP_W  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_dz;
  logic             out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_dz, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_dz, out_illegal
  );
endinterface

// File: rtl/tinker_iter_alu_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is resolved on the start edge.
module tinker_iter_divider
  import tinker_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [XLEN-1:0]  rem, quo, dvsr;
  logic [CNT_W-1:0] cnt;
  logic             run;

  logic [XLEN-1:0]  rem_src, quo_src, dvsr_src;
  logic [XLEN:0]    shifted, diff;
  logic [XLEN-1:0]  rem_step, quo_step;

  always_comb begin
    rem_src  = start ? '0 : rem;
    quo_src  = start ? dividend : quo;
    dvsr_src = start ? divisor : dvsr;
    shifted  = {rem_src, quo_src[XLEN-1]};
    diff     = shifted - {1'b0, dvsr_src};
    rem_step = shifted[XLEN-1:0];
    quo_step = {quo_src[XLEN-2:0], 1'b0};
    // Non-negative trial difference: keep it and set the quotient bit.
    if (!diff[XLEN]) begin
      rem_step = diff[XLEN-1:0];
      quo_step = {quo_src[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem  <= '0;
      quo  <= '0;
      dvsr <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      rem  <= rem_step;
      quo  <= quo_step;
      dvsr <= divisor;
      cnt  <= CNT_W'(XLEN - 1);
      run  <= 1'b1;
    end else if (run) begin
      if (cnt != '0) begin
        rem <= rem_step;
        quo <= quo_step;
        cnt <= cnt - CNT_W'(1);
      end else begin
        run <= 1'b0;
      end
    end
  end

  assign done     = run && (cnt == '0);
  assign quotient = quo;

endmodule

// File: rtl/tinker_iter_alu.sv
// Handshaked multi-cycle execute unit: single-cycle add/sub/logic, iterative mul and div.
// Define TINKER_ALU_FAST_MUL_EN for a single-cycle combinational multiplier.
//
// state  | meaning
// S_IDLE | ready for a request
// S_MUL  | shift-add multiply in progress
// S_DIV  | restoring divide in progress (sub-module)
// S_DONE | result presented, waiting for out_ready
module tinker_iter_alu
  import tinker_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  output logic             busy,
  tinker_iter_alu_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  state_t           state, state_nxt;
  logic [XLEN-1:0]  res_q, mcand, mplier, acc, acc_nxt;
  logic [TAG_W-1:0] tag_q;
  logic             dz_q, ill_q;
  logic [CNT_W-1:0] cnt;
  logic             accept, div_start, div_done;
  logic [XLEN-1:0]  div_quotient;

  assign accept    = bus.in_valid && (state == S_IDLE) && !flush;
  assign div_start = accept && (bus.in_op == OP_DIV) && (bus.in_b != '0);
  assign acc_nxt   = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
    busy          = (state != S_IDLE);
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_op == OP_MUL && !is_single_cycle(bus.in_op)) state_nxt = S_MUL;
            else if (div_start)                                      state_nxt = S_DIV;
            else                                                     state_nxt = S_DONE;
          end
        end
        S_MUL:   if (cnt == CNT_W'(1)) state_nxt = S_DONE;
        S_DIV:   if (div_done)         state_nxt = S_DONE;
        S_DONE:  if (bus.out_ready)    state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q  <= '0;
      tag_q  <= '0;
      dz_q   <= 1'b0;
      ill_q  <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            tag_q <= bus.in_tag;
            dz_q  <= 1'b0;
            ill_q <= 1'b0;
            res_q <= '0;
            case (bus.in_op)
              OP_ADD, OP_ADDI: res_q <= bus.in_a + bus.in_b;
              OP_SUB, OP_SUBI: res_q <= bus.in_a - bus.in_b;
              OP_AND:          res_q <= bus.in_a & bus.in_b;
              OP_OR:           res_q <= bus.in_a | bus.in_b;
              OP_XOR:          res_q <= bus.in_a ^ bus.in_b;
              OP_NOT:          res_q <= ~bus.in_a;
              OP_MUL: begin
`ifdef TINKER_ALU_FAST_MUL_EN
                res_q <= bus.in_a * bus.in_b;
`else
                mcand  <= bus.in_a;
                mplier <= bus.in_b;
                acc    <= '0;
                cnt    <= CNT_W'(XLEN);
`endif
              end
              OP_DIV: begin
                if (bus.in_b == '0) begin
                  res_q <= '1;
                  dz_q  <= 1'b1;
                end
              end
              default: ill_q <= 1'b1;
            endcase
          end
        end
        S_MUL: begin
          // The last partial product lands straight in the result register.
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) res_q <= acc_nxt;
        end
        S_DIV: if (div_done) res_q <= div_quotient;
        default: ;
      endcase
    end
  end

  tinker_iter_divider #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .start    (div_start),
    .dividend (bus.in_a),
    .divisor  (bus.in_b),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign bus.out_result  = res_q;
  assign bus.out_tag     = tag_q;
  assign bus.out_dz      = dz_q;
  assign bus.out_illegal = ill_q;

endmodule

// File: tb/tb_tinker_iter_alu.sv
// Bench for tinker_iter_alu: directed cases plus random ops against an arithmetic reference model.
module tb_tinker_iter_alu;
  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy;
  int   n_chk = 0;
  int   n_bad = 0;

  tinker_iter_alu_if #(.XLEN(64), .TAG_W(5), .OP_W(5)) bus();

  tinker_iter_alu #(.XLEN(64), .TAG_W(5), .OP_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic dz, output logic ill,
                                output int lat);
    dz = 1'b0; ill = 1'b0; lat = 1; r = 64'd0;
    case (op)
      5'b11000, 5'b11001: r = a + b;
      5'b11010, 5'b11011: r = a - b;
      5'b00000: r = a & b;
      5'b00001: r = a | b;
      5'b00010: r = a ^ b;
      5'b00011: r = ~a;
      5'b11100: begin
        r = a * b;
`ifdef TINKER_ALU_FAST_MUL_EN
        lat = 1;
`else
        lat = 65;
`endif
      end
      5'b11101: begin
        if (b == 64'd0) begin r = '1; dz = 1'b1; end
        else begin r = a / b; lat = 65; end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic drive(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  task automatic do_op(input string name, input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag);
    logic [63:0] er;
    logic        edz, eill;
    int          elat, lat, n, ready_bad;
    model(op, a, b, er, edz, eill, elat);
    n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk({name, "_ready_wait"}, 64'(bus.in_ready), 64'd1);
    drive(op, a, b, tag);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    ready_bad = 0;
    while (!bus.out_valid && lat < 300) begin
      if (bus.in_ready) ready_bad++;
      tick();
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(elat));
    chk({name, "_res"}, bus.out_result, er);
    chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
    chk({name, "_dz"}, 64'(bus.out_dz), 64'(edz));
    chk({name, "_ill"}, 64'(bus.out_illegal), 64'(eill));
    chk({name, "_rdy_low"}, 64'(ready_bad), 64'd0);
    tick();
    chk({name, "_rdy_after"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [4:0]  legal [10];
    logic [4:0]  op;
    logic [63:0] a, b;
    int          vcount;
    legal = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b11000,
              5'b11001, 5'b11010, 5'b11011, 5'b11100, 5'b11101};

    reset = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", bus.out_result, 64'd0);
    chk("rst_flags", 64'({bus.out_tag, bus.out_dz, bus.out_illegal}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    do_op("add", 5'b11000, 64'd5, 64'd7, 5'd3);
    do_op("sub_wrap", 5'b11010, 64'd0, 64'd1, 5'd4);
    do_op("mul", 5'b11100, 64'h1_0000_0001, 64'd3, 5'd5);
    do_op("div", 5'b11101, 64'd100, 64'd7, 5'd6);
    do_op("div_zero", 5'b11101, 64'd42, 64'd0, 5'd7);
    do_op("illegal", 5'b01111, 64'd9, 64'd9, 5'd8);
    do_op("not", 5'b00011, 64'h0123_4567_89AB_CDEF, 64'd0, 5'd1);

    // Backpressure: result held while out_ready is low and new requests are ignored.
    bus.out_ready = 1'b0;
    drive(5'b00010, 64'hF0, 64'hFF, 5'd9);
    tick();
    drive(5'b11000, 64'd1, 64'd1, 5'd2);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_result", bus.out_result, 64'h0F);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    chk("bp_tag", 64'(bus.out_tag), 64'd9);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_retire_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_retire_valid", 64'(bus.out_valid), 64'd0);

    // Flush on cycle 20 of a mul.
    drive(5'b11100, 64'd123, 64'd456, 5'd10);
    tick();
    bus.in_valid = 1'b0;
    repeat (19) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready", 64'(bus.in_ready), 64'd1);
    vcount = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.out_valid) vcount++;
      tick();
    end
    chk("flush_no_valid", 64'(vcount), 64'd0);
    do_op("add_after_flush", 5'b11000, 64'd1000, 64'd24, 5'd11);

    // Flush with a request in idle: request dropped.
    flush = 1'b1;
    drive(5'b11000, 64'd1, 64'd2, 5'd12);
    tick();
    bus.in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);
    tick();
    chk("flush_idle_valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset during a divide.
    drive(5'b11101, 64'd100, 64'd7, 5'd13);
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_result", bus.out_result, 64'd0);
    chk("arst_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus.out_valid) vcount++;
    end
    chk("arst_no_valid", 64'(vcount), 64'd0);

    // Random ops against the reference model.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) < 2) op = 5'($urandom_range(0, 31));
      else                          op = legal[$urandom_range(0, 9)];
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = 64'($urandom_range(0, 255));
        1: b = 64'($urandom);
        default: b = {$urandom, $urandom};
      endcase
      if (op == 5'b11101 && $urandom_range(0, 5) == 0) b = 64'd0;
      do_op($sformatf("rnd%0d_op%0h", i, op), op, a, b, 5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
